// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the 8-bit multi-cycle processor control.
// ULA codes, opcodes, FSM states, mux selects and the control bundle.
package controle_multiciclo_pkg;

  localparam int LARGURA_OP_PAD  = 4;
  localparam int LARGURA_EST_PAD = 4;

  localparam logic [1:0] ULA_ADD = 2'b00;
  localparam logic [1:0] ULA_SUB = 2'b01;
  localparam logic [1:0] ULA_AND = 2'b10;
  localparam logic [1:0] ULA_OR  = 2'b11;

  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_J    = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic       FA_PC     = 1'b0;
  localparam logic       FA_REG    = 1'b1;
  localparam logic [1:0] FB_REG    = 2'b00;
  localparam logic [1:0] FB_UM     = 2'b01;
  localparam logic [1:0] FB_IMM    = 2'b10;
  localparam logic [1:0] PC_ULA    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SALTO  = 2'b10;
  localparam logic       END_PC    = 1'b0;
  localparam logic       END_ALU   = 1'b1;

  typedef enum logic [3:0] {
    INICIO   = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    ESCR_R   = 4'd4,
    END_MEM  = 4'd5,
    LER_MEM  = 4'd6,
    ESCR_MEM = 4'd7,
    GRAV_MEM = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    HALT     = 4'd11
  } estado_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       ula_fonte_a;
    logic [1:0] ula_fonte_b;
    logic [1:0] pc_fonte;
    logic       pc_escreve;
    logic       ir_escreve;
    logic       iord;
    logic       mem_le;
    logic       mem_escreve;
    logic       reg_escreve;
    logic       mem_para_reg;
    logic       parado;
  } ctrl_t;

  function automatic logic eh_tipo_r(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

  function automatic logic eh_mem(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/controle_multiciclo_decodificador_saidas.sv
// Combinational state -> control vector decoder.
// Only FETCH and BRANCH look at handshake/flag inputs.
module decodificador_saidas
  import controle_multiciclo_pkg::*;
(
  input  estado_t    est,
  input  logic [1:0] funcao,
  input  logic       zero,
  input  logic       mem_pronto,
  output ctrl_t      ctrl
);

  // Everything defaults to 0; each state raises only its own controls.
  always_comb begin
    ctrl = '0;
    case (est)
      FETCH: begin
        ctrl.mem_le      = 1'b1;
        ctrl.iord        = END_PC;
        ctrl.ula_fonte_a = FA_PC;
        ctrl.ula_fonte_b = FB_UM;
        ctrl.alu_op      = ULA_ADD;
        ctrl.pc_fonte    = PC_ULA;
        ctrl.ir_escreve  = mem_pronto;
        ctrl.pc_escreve  = mem_pronto;
      end
      DECODE: begin
        ctrl.ula_fonte_a = FA_PC;
        ctrl.ula_fonte_b = FB_IMM;
        ctrl.alu_op      = ULA_ADD;
      end
      EXEC_R: begin
        ctrl.ula_fonte_a = FA_REG;
        ctrl.ula_fonte_b = FB_REG;
        ctrl.alu_op      = funcao;
      end
      ESCR_R: begin
        ctrl.reg_escreve  = 1'b1;
        ctrl.mem_para_reg = 1'b0;
      end
      END_MEM: begin
        ctrl.ula_fonte_a = FA_REG;
        ctrl.ula_fonte_b = FB_IMM;
        ctrl.alu_op      = ULA_ADD;
      end
      LER_MEM: begin
        ctrl.mem_le = 1'b1;
        ctrl.iord   = END_ALU;
      end
      ESCR_MEM: begin
        ctrl.reg_escreve  = 1'b1;
        ctrl.mem_para_reg = 1'b1;
      end
      GRAV_MEM: begin
        ctrl.mem_escreve = 1'b1;
        ctrl.iord        = END_ALU;
      end
      BRANCH: begin
        ctrl.ula_fonte_a = FA_REG;
        ctrl.ula_fonte_b = FB_REG;
        ctrl.alu_op      = ULA_SUB;
        ctrl.pc_fonte    = PC_ALUOUT;
        ctrl.pc_escreve  = zero;
      end
      JUMP: begin
        ctrl.pc_fonte   = PC_SALTO;
        ctrl.pc_escreve = 1'b1;
      end
      HALT: begin
        ctrl.parado = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle control FSM: state register plus next-state logic.
// Control outputs come from decodificador_saidas.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int LARGURA_OP  = 4,
  parameter int LARGURA_EST = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [LARGURA_OP-1:0]  opcode,
  input  logic                   zero,
  input  logic                   mem_pronto,
  output logic [1:0]             alu_op,
  output logic                   ula_fonte_a,
  output logic [1:0]             ula_fonte_b,
  output logic [1:0]             pc_fonte,
  output logic                   pc_escreve,
  output logic                   ir_escreve,
  output logic                   iord,
  output logic                   mem_le,
  output logic                   mem_escreve,
  output logic                   reg_escreve,
  output logic                   mem_para_reg,
  output logic                   parado,
  output logic [LARGURA_EST-1:0] estado
);

  estado_t    est;
  estado_t    prox;
  logic [3:0] op;
  ctrl_t      ctrl;

  assign op = 4'(opcode);

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clock) begin
    if (reset) est <= INICIO;
    else       est <= prox;
  end

  // Next state: dispatch in DECODE, stall on memory handshake.
  always_comb begin
    prox = est;
    case (est)
      INICIO: prox = FETCH;
      FETCH: if (mem_pronto) prox = DECODE;
      DECODE: begin
        unique case (1'b1)
          eh_tipo_r(op):     prox = EXEC_R;
          eh_mem(op):        prox = END_MEM;
          (op == OP_BEQ):    prox = BRANCH;
          (op == OP_J):      prox = JUMP;
          (op == OP_HALT):   prox = HALT;
          default:           prox = FETCH;
        endcase
      end
      EXEC_R:   prox = ESCR_R;
      ESCR_R:   prox = FETCH;
      END_MEM:  prox = (op == OP_LW) ? LER_MEM : GRAV_MEM;
      LER_MEM:  if (mem_pronto) prox = ESCR_MEM;
      ESCR_MEM: prox = FETCH;
      GRAV_MEM: if (mem_pronto) prox = FETCH;
      BRANCH:   prox = FETCH;
      JUMP:     prox = FETCH;
      HALT:     prox = HALT;
      default:  prox = FETCH;
    endcase
  end

  decodificador_saidas u_dec (
    .est        (est),
    .funcao     (op[1:0]),
    .zero       (zero),
    .mem_pronto (mem_pronto),
    .ctrl       (ctrl)
  );

  assign alu_op       = ctrl.alu_op;
  assign ula_fonte_a  = ctrl.ula_fonte_a;
  assign ula_fonte_b  = ctrl.ula_fonte_b;
  assign pc_fonte     = ctrl.pc_fonte;
  assign pc_escreve   = ctrl.pc_escreve;
  assign ir_escreve   = ctrl.ir_escreve;
  assign iord         = ctrl.iord;
  assign mem_le       = ctrl.mem_le;
  assign mem_escreve  = ctrl.mem_escreve;
  assign reg_escreve  = ctrl.reg_escreve;
  assign mem_para_reg = ctrl.mem_para_reg;
  assign parado       = ctrl.parado;
  assign estado       = LARGURA_EST'(est);

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed scenarios with literal
// expectations, then random traffic against an instruction-level model.
module tb_controle_multiciclo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0;
  logic       mem_pronto = 1'b0;
  logic [1:0] alu_op;
  logic       ula_fonte_a;
  logic [1:0] ula_fonte_b;
  logic [1:0] pc_fonte;
  logic       pc_escreve;
  logic       ir_escreve;
  logic       iord;
  logic       mem_le;
  logic       mem_escreve;
  logic       reg_escreve;
  logic       mem_para_reg;
  logic       parado;
  logic [3:0] estado;

  controle_multiciclo #(.LARGURA_OP(4), .LARGURA_EST(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .opcode       (opcode),
    .zero         (zero),
    .mem_pronto   (mem_pronto),
    .alu_op       (alu_op),
    .ula_fonte_a  (ula_fonte_a),
    .ula_fonte_b  (ula_fonte_b),
    .pc_fonte     (pc_fonte),
    .pc_escreve   (pc_escreve),
    .ir_escreve   (ir_escreve),
    .iord         (iord),
    .mem_le       (mem_le),
    .mem_escreve  (mem_escreve),
    .reg_escreve  (reg_escreve),
    .mem_para_reg (mem_para_reg),
    .parado       (parado),
    .estado       (estado)
  );

  always #5 clock = ~clock;

  // {alu_op, fa, fb, pcf, pcw, irw, iord, le, we, rw, m2r, parado, 0}
  logic [15:0] dut_vec;
  assign dut_vec = {alu_op, ula_fonte_a, ula_fonte_b, pc_fonte,
                    pc_escreve, ir_escreve, iord, mem_le, mem_escreve,
                    reg_escreve, mem_para_reg, parado, 1'b0};

  int n_chk = 0;
  int n_ok  = 0;

  // Model: current step number plus the steps the instruction still owes.
  int  m_est = 0;
  bit  m_ok  = 0;
  int  plan[$];

  logic [15:0] s_out;
  logic [3:0]  s_est;

  task automatic chk(input string nome, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nome, got, exp, $time);
  endtask

  function automatic logic [15:0] esperado(input int st, input logic [3:0] op,
                                           input logic z, input logic mp);
    logic [1:0] a = 2'b00;
    logic [1:0] fb = 2'b00;
    logic [1:0] pf = 2'b00;
    logic fa = 0, pcw = 0, irw = 0, io = 0, le = 0;
    logic we = 0, rw = 0, mr = 0, hp = 0;
    case (st)
      1:  begin le = 1; fb = 2'b01; pcw = mp; irw = mp; end
      2:  fb = 2'b10;
      3:  begin fa = 1; a = op[1:0]; end
      4:  rw = 1;
      5:  begin fa = 1; fb = 2'b10; end
      6:  begin le = 1; io = 1; end
      7:  begin rw = 1; mr = 1; end
      8:  begin we = 1; io = 1; end
      9:  begin fa = 1; a = 2'b01; pf = 2'b01; pcw = z; end
      10: begin pf = 2'b10; pcw = 1; end
      11: hp = 1;
      default: ;
    endcase
    return {a, fa, fb, pf, pcw, irw, io, le, we, rw, mr, hp, 1'b0};
  endfunction

  // Steps an instruction walks after DECODE, chosen by its opcode.
  function automatic void plano(input logic [3:0] op);
    plan.delete();
    if (op <= 4'd3) begin plan.push_back(3); plan.push_back(4); end
    else if (op == 4'd4) begin
      plan.push_back(5); plan.push_back(6); plan.push_back(7);
    end
    else if (op == 4'd5) begin plan.push_back(5); plan.push_back(8); end
    else if (op == 4'd6) plan.push_back(9);
    else if (op == 4'd7) plan.push_back(10);
    else if (op == 4'd15) plan.push_back(11);
  endfunction

  task automatic step(input bit r, input logic [3:0] op, input bit z,
                      input bit mp, input int exp_est);
    @(negedge clock);
    reset = r; opcode = op; zero = z; mem_pronto = mp;
    #1;
    s_out = dut_vec;
    s_est = estado;
    if (exp_est >= 0) chk("estado_lit", {12'd0, estado}, 16'(exp_est));
    if (m_ok) begin
      chk("estado", {12'd0, estado}, 16'(m_est));
      chk("saidas", dut_vec, esperado(m_est, op, z, mp));
      chk("exclusao", {14'd0, mem_le & mem_escreve,
                       reg_escreve & pc_escreve}, 16'd0);
    end
    @(posedge clock);
    if (r) begin
      m_est = 0; plan.delete(); m_ok = 1;
    end else if (m_ok) begin
      case (m_est)
        0:  m_est = 1;
        1:  if (mp) begin m_est = 2; plano(op); end
        6, 8: if (mp) m_est = (plan.size() > 0) ? plan.pop_front() : 1;
        11: ;
        default: m_est = (plan.size() > 0) ? plan.pop_front() : 1;
      endcase
    end
  endtask

  initial begin
    logic [3:0] rop;
    bit rr;

    step(1, 4'd0, 0, 0, -1);
    step(1, 4'd0, 0, 0, 0);
    chk("inicio_saidas", s_out, 16'd0);
    step(0, 4'd0, 0, 1, 0);

    // R-type SUB
    step(0, 4'd1, 0, 1, 1);
    chk("r_fetch_irw", {15'd0, s_out[7]}, 16'd1);
    step(0, 4'd1, 0, 1, 2);
    step(0, 4'd1, 0, 1, 3);
    chk("r_alu_op", {14'd0, s_out[15:14]}, 16'd1);
    chk("r_rw_exec", {15'd0, s_out[3]}, 16'd0);
    step(0, 4'd1, 0, 1, 4);
    chk("r_rw_escr", {15'd0, s_out[3]}, 16'd1);

    // LW with three wait cycles
    step(0, 4'd4, 0, 1, 1);
    step(0, 4'd4, 0, 1, 2);
    step(0, 4'd4, 0, 1, 5);
    repeat (3) begin
      step(0, 4'd4, 0, 0, 6);
      chk("lw_le_iord", {14'd0, s_out[5], s_out[6]}, 16'd3);
    end
    step(0, 4'd4, 0, 1, 6);
    step(0, 4'd4, 0, 1, 7);
    chk("lw_m2r", {15'd0, s_out[2]}, 16'd1);

    // BEQ taken, then not taken
    step(0, 4'd6, 1, 1, 1);
    step(0, 4'd6, 1, 1, 2);
    step(0, 4'd6, 1, 1, 9);
    chk("beq_taken", {13'd0, s_out[10:8]}, 16'b011);
    step(0, 4'd6, 0, 1, 1);
    step(0, 4'd6, 0, 1, 2);
    step(0, 4'd6, 0, 1, 9);
    chk("beq_not_taken", {15'd0, s_out[8]}, 16'd0);

    // illegal opcode behaves as NOP
    step(0, 4'd10, 0, 1, 1);
    step(0, 4'd10, 0, 1, 2);
    chk("nop_sem_escrita", {12'd0, s_out[8], s_out[7], s_out[4], s_out[3]}, 16'd0);

    // HALT holds until reset
    step(0, 4'd15, 0, 1, 1);
    step(0, 4'd15, 0, 1, 2);
    repeat (10) begin
      step(0, 4'd15, 0, 1, 11);
      chk("halt_parado", {15'd0, s_out[1]}, 16'd1);
    end
    step(1, 4'd15, 0, 1, 11);
    step(0, 4'd5, 0, 1, 0);
    chk("reset_limpa_parado", {15'd0, s_out[1]}, 16'd0);

    // SW aborted by reset mid-access
    step(0, 4'd5, 0, 1, 1);
    step(0, 4'd5, 0, 1, 2);
    step(0, 4'd5, 0, 1, 5);
    step(1, 4'd5, 0, 0, 8);
    chk("sw_we", {15'd0, s_out[4]}, 16'd1);
    step(0, 4'd5, 0, 1, 0);
    chk("sw_abort_we", {15'd0, s_out[4]}, 16'd0);

    // random traffic
    rop = 4'd0;
    for (int i = 0; i < 4000; i++) begin
      rr = ($urandom_range(0, 63) == 0) ||
           (m_est == 11 && $urandom_range(0, 7) == 0);
      if (m_est <= 1) rop = 4'($urandom_range(0, 15));
      step(rr, rop, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, -1);
    end

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
